// File: rtl/lut_dds_quarter_mc.sv
// lut_dds_quarter_mc
// Multi-channel DDS. Each channel owns a phase accumulator. All channels
// share one runtime-loadable quarter-wave LUT. Quadrant mirroring rebuilds
// the full period from the quarter wave. Once per sample tick the channels
// are issued one per cycle through a single two-stage read pipeline. All
// channel outputs are then committed together.
//
// Optional feature macro: LUT_DDS_UNSIGNED_OUT_EN
//   defined   -> offset-binary samples (MSB inverted)
//   undefined -> two's-complement samples
//
// Ports
//   CLK_SYS    system clock, rising edge
//   nRST       asynchronous active-low reset
//   EN         run enable; low aborts the frame and clears OVERRUN
//   SYNC       clears every phase accumulator on the next edge
//   WAIT_CYC   sample period minus one, in clocks
//   FTW        per-channel frequency tuning words, ACC_WIDTH each
//   PHASE_OFS  per-channel phase offsets, ACC_WIDTH each
//   LUT_WE     LUT write strobe
//   LUT_ADDR   LUT write address
//   LUT_DATA   LUT write magnitude (BIT_WIDTH-1 bits)
//   OUT_DATA   per-channel samples, BIT_WIDTH each
//   OUT_VALID  one-cycle pulse when OUT_DATA updates
//   CH_WRAP    per-channel accumulator-wrap flags, valid with OUT_VALID
//   OVERRUN    sticky flag for a dropped tick
module lut_dds_quarter_mc #(
    parameter int BIT_WIDTH      = 16,
    parameter int LUT_DEPTH_LOG2 = 8,
    parameter int ACC_WIDTH      = 24,
    parameter int NUM_CH         = 2,
    parameter int WAIT_WIDTH     = 12
) (
    input  logic                        CLK_SYS,
    input  logic                        nRST,
    input  logic                        EN,
    input  logic                        SYNC,
    input  logic [WAIT_WIDTH-1:0]       WAIT_CYC,
    input  logic [NUM_CH*ACC_WIDTH-1:0] FTW,
    input  logic [NUM_CH*ACC_WIDTH-1:0] PHASE_OFS,
    input  logic                        LUT_WE,
    input  logic [LUT_DEPTH_LOG2-1:0]   LUT_ADDR,
    input  logic [BIT_WIDTH-2:0]        LUT_DATA,
    output logic [NUM_CH*BIT_WIDTH-1:0] OUT_DATA,
    output logic                        OUT_VALID,
    output logic [NUM_CH-1:0]           CH_WRAP,
    output logic                        OVERRUN
);

    localparam int LUT_DEPTH = 1 << LUT_DEPTH_LOG2;
    localparam int CNT_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef LUT_DDS_UNSIGNED_OUT_EN
    localparam logic [BIT_WIDTH-1:0] FMT_XOR = {1'b1, {(BIT_WIDTH-1){1'b0}}};
`else
    localparam logic [BIT_WIDTH-1:0] FMT_XOR = {BIT_WIDTH{1'b0}};
`endif
    localparam logic [NUM_CH*BIT_WIDTH-1:0] OUT_RST = {NUM_CH{FMT_XOR}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Turn a LUT magnitude into a signed sample. Lower half-period
    // quadrants negate. The result is then put in the output number format.
    function automatic logic [BIT_WIDTH-1:0] to_sample(
        input logic [BIT_WIDTH-2:0] mag,
        input logic                 neg
    );
        logic [BIT_WIDTH-1:0] ext;
        ext = {1'b0, mag};
        if (neg) begin
            ext = ~ext + {{(BIT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            ext = ext;
        end
        return ext ^ FMT_XOR;
    endfunction

    // Odd quadrants walk the quarter wave backwards.
    function automatic logic [LUT_DEPTH_LOG2-1:0] mirror_addr(
        input logic [LUT_DEPTH_LOG2-1:0] addr,
        input logic                      odd_quad
    );
        logic [LUT_DEPTH_LOG2-1:0] res;
        if (odd_quad) begin
            res = ~addr;
        end else begin
            res = addr;
        end
        return res;
    endfunction

    state_t                      state_r, state_next_s;
    logic [CNT_W-1:0]            step_r, step_next_s;
    logic                        drain_r, drain_next_s;
    logic                        issue_s, commit_s, tick_s;
    logic [WAIT_WIDTH-1:0]       tick_cnt_r;

    logic [NUM_CH*ACC_WIDTH-1:0] acc_r;
    logic [NUM_CH-1:0]           wrap_r;
    logic [ACC_WIDTH-1:0]        acc_sel_s, ftw_sel_s, ofs_sel_s, ph_s;
    logic [ACC_WIDTH:0]          acc_sum_s;
    logic [1:0]                  quad_s;
    logic [LUT_DEPTH_LOG2-1:0]   rd_addr_s;
    logic                        unused_ph_s;

    logic [BIT_WIDTH-2:0]        lut_mem [LUT_DEPTH];
    logic [BIT_WIDTH-2:0]        mag_p1_r;
    logic                        neg_p1_r;
    logic                        vld_p1_r;
    logic [CNT_W-1:0]            ch_p1_r;

    logic [NUM_CH*BIT_WIDTH-1:0] shadow_r, out_data_r;
    logic                        out_valid_r;
    logic [NUM_CH-1:0]           ch_wrap_r;
    logic                        overrun_r;

    assign tick_s = EN && (tick_cnt_r == WAIT_CYC);

    // Sample-period counter. If WAIT_CYC is lowered below the current count,
    // the counter wraps to 0 without a tick instead of running the full range.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            tick_cnt_r <= {WAIT_WIDTH{1'b0}};
        end else if (!EN) begin
            tick_cnt_r <= {WAIT_WIDTH{1'b0}};
        end else if (tick_cnt_r >= WAIT_CYC) begin
            tick_cnt_r <= {WAIT_WIDTH{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + {{(WAIT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Frame sequencer: next state, issue strobe and commit strobe.
    always_comb begin
        state_next_s = state_r;
        step_next_s  = step_r;
        drain_next_s = drain_r;
        issue_s      = 1'b0;
        if (!EN) begin
            state_next_s = ST_IDLE;
            step_next_s  = {CNT_W{1'b0}};
            drain_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        state_next_s = ST_ISSUE;
                        step_next_s  = {CNT_W{1'b0}};
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    issue_s = 1'b1;
                    if (step_r == CNT_W'(NUM_CH - 1)) begin
                        state_next_s = ST_DRAIN;
                        step_next_s  = {CNT_W{1'b0}};
                        drain_next_s = 1'b0;
                    end else begin
                        step_next_s = step_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DRAIN: begin
                    if (drain_r) begin
                        state_next_s = ST_COMMIT;
                        drain_next_s = 1'b0;
                    end else begin
                        drain_next_s = 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                    step_next_s  = {CNT_W{1'b0}};
                    drain_next_s = 1'b0;
                end
            endcase
        end
    end

    // Outputs are loaded on the edge entering COMMIT, so OUT_VALID is high
    // during the COMMIT cycle itself.
    assign commit_s = (state_next_s == ST_COMMIT);

    // Frame sequencer state register.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
            step_r  <= {CNT_W{1'b0}};
            drain_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            step_r  <= step_next_s;
            drain_r <= drain_next_s;
        end
    end

    // Phase for the channel being issued, plus the mirrored LUT address.
    always_comb begin
        acc_sel_s = acc_r[step_r*ACC_WIDTH +: ACC_WIDTH];
        ftw_sel_s = FTW[step_r*ACC_WIDTH +: ACC_WIDTH];
        ofs_sel_s = PHASE_OFS[step_r*ACC_WIDTH +: ACC_WIDTH];
        ph_s      = acc_sel_s + ofs_sel_s;
        acc_sum_s = {1'b0, acc_sel_s} + {1'b0, ftw_sel_s};
        quad_s    = ph_s[ACC_WIDTH-1 -: 2];
        rd_addr_s = mirror_addr(ph_s[ACC_WIDTH-3 -: LUT_DEPTH_LOG2], quad_s[0]);
    end

    // Low phase bits below the LUT address are intentionally discarded.
    assign unused_ph_s = ^ph_s;

    // Phase accumulators. SYNC takes priority over an issue update.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            acc_r <= {(NUM_CH*ACC_WIDTH){1'b0}};
        end else if (SYNC) begin
            acc_r <= {(NUM_CH*ACC_WIDTH){1'b0}};
        end else if (issue_s) begin
            acc_r[step_r*ACC_WIDTH +: ACC_WIDTH] <= acc_sum_s[ACC_WIDTH-1:0];
        end else begin
            acc_r <= acc_r;
        end
    end

    // Accumulator carry-out per channel, committed alongside the samples.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            wrap_r <= {NUM_CH{1'b0}};
        end else if (issue_s) begin
            wrap_r[step_r] <= acc_sum_s[ACC_WIDTH];
        end else begin
            wrap_r <= wrap_r;
        end
    end

    // LUT write port. Contents are not reset.
    always_ff @(posedge CLK_SYS) begin
        if (LUT_WE) begin
            lut_mem[LUT_ADDR] <= LUT_DATA;
        end
    end

    // Stage 1: registered LUT read. A same-cycle write to the same address
    // returns the old data.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            mag_p1_r <= {(BIT_WIDTH-1){1'b0}};
            neg_p1_r <= 1'b0;
            ch_p1_r  <= {CNT_W{1'b0}};
            vld_p1_r <= 1'b0;
        end else if (issue_s) begin
            mag_p1_r <= lut_mem[rd_addr_s];
            neg_p1_r <= quad_s[1];
            ch_p1_r  <= step_r;
            vld_p1_r <= 1'b1;
        end else begin
            vld_p1_r <= 1'b0;
        end
    end

    // Stage 2: sign the magnitude into the per-channel shadow register.
    // EN low flushes the in-flight read.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            shadow_r <= OUT_RST;
        end else if (EN && vld_p1_r) begin
            shadow_r[ch_p1_r*BIT_WIDTH +: BIT_WIDTH] <= to_sample(mag_p1_r, neg_p1_r);
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Commit: all channels and wrap flags update together.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            out_data_r  <= OUT_RST;
            ch_wrap_r   <= {NUM_CH{1'b0}};
            out_valid_r <= 1'b0;
        end else if (commit_s) begin
            out_data_r  <= shadow_r;
            ch_wrap_r   <= wrap_r;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    // Sticky overrun flag. A tick outside IDLE is dropped; EN low clears it.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            overrun_r <= 1'b0;
        end else if (!EN) begin
            overrun_r <= 1'b0;
        end else if (tick_s && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign OUT_DATA  = out_data_r;
    assign OUT_VALID = out_valid_r;
    assign CH_WRAP   = ch_wrap_r;
    assign OVERRUN   = overrun_r;

endmodule
